// File: rtl/sd_pkg.sv
// Shared SD sequencer definitions: command frames, FSM encodings, error codes.
package sd_pkg;

  localparam logic [47:0] FRAME_CMD0   = 48'h40_00000000_95;
  localparam logic [47:0] FRAME_CMD8   = 48'h48_000001AA_87;
  localparam logic [47:0] FRAME_CMD55  = 48'h77_00000000_65;
  localparam logic [47:0] FRAME_ACMD41 = 48'h69_40000000_77;
  localparam logic [7:0]  CMD17_IDX    = 8'h51;

  localparam logic [2:0] ERR_CMD0       = 3'd1;
  localparam logic [2:0] ERR_CMD8       = 3'd2;
  localparam logic [2:0] ERR_RETRY      = 3'd3;
  localparam logic [2:0] ERR_R1_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_CMD17      = 3'd5;
  localparam logic [2:0] ERR_TOKEN      = 3'd6;

  localparam int CNT_W   = 13;
  localparam int RETRY_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_SEND_WAIT, ST_READ, ST_READ_WAIT, ST_DONE
  } state_t;

  typedef enum logic [3:0] {
    STEP_CMD0, STEP_CMD8, STEP_ECHO, STEP_CMD55, STEP_ACMD41,
    STEP_CMD17, STEP_TOKEN, STEP_DATA, STEP_CRC
  } step_t;

  function automatic logic is_r1_step(step_t s);
    return s inside {STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD17};
  endfunction

  function automatic logic is_init_step(step_t s);
    return s inside {STEP_CMD0, STEP_CMD8, STEP_ECHO, STEP_CMD55, STEP_ACMD41};
  endfunction

  function automatic logic [47:0] cmd_frame(step_t s, logic [31:0] addr);
    case (s)
      STEP_CMD0:   return FRAME_CMD0;
      STEP_CMD8:   return FRAME_CMD8;
      STEP_CMD55:  return FRAME_CMD55;
      STEP_ACMD41: return FRAME_ACMD41;
      STEP_CMD17:  return {CMD17_IDX, addr, 8'hFF};
      default:     return 48'h0;
    endcase
  endfunction

endpackage

// File: rtl/sd_byte_packer.sv
// Packs data bytes big-endian into 32-bit words; writes each word one cycle after its 4th byte.
// No backpressure: RAM port 2 is dedicated and accepts a write every cycle.
module sd_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] base,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_data
);

  logic [31:0] word;
  logic [1:0]  byte_cnt;
  logic [6:0]  word_idx;
  logic [11:0] base_q;
  logic [4:0]  lsb;

  // byte 0 of a word lands in bits [31:24], byte 3 in [7:0]
  assign lsb = {~byte_cnt, 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word     <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      base_q   <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_we <= 1'b0;
      if (load) begin
        base_q   <= base;
        byte_cnt <= '0;
        word_idx <= '0;
      end else if (byte_vld) begin
        word[lsb +: 8] <= byte_dat;
        byte_cnt       <= byte_cnt + 1'b1;
        if (byte_cnt == 2'd3) begin
          ram_we   <= 1'b1;
          ram_data <= {word[31:8], byte_dat};
          ram_addr <= base_q + {5'b0, word_idx};
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sd_block_sequencer.sv
// SPI-mode SD init (CMD0/CMD8/CMD55+ACMD41, once) then CMD17 single-block read into RAM port 2.
// One SD transaction outstanding at a time; start is ignored while busy.
module sd_block_sequencer
  import sd_pkg::*;
#(
  parameter int RESP_TIMEOUT  = 16,
  parameter int TOKEN_TIMEOUT = 4096,
  parameter int INIT_RETRIES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] block_addr,
  input  logic [11:0] ram_base,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        card_ready,
  output logic [47:0] sd_cmd,
  output logic        sd_start,
  output logic        sd_read,
  input  logic        sd_resp_valid,
  input  logic [7:0]  sd_resp,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_data
);

  state_t state, state_nxt;
  step_t  step, step_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic [31:0] addr_q;
  logic        fail, ready_set, start_acc, byte_vld;
  logic [2:0]  fail_code;

  assign start_acc = (state == ST_IDLE) && start;
  assign byte_vld  = (state == ST_READ_WAIT) && sd_resp_valid && (step == STEP_DATA);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign sd_start  = (state == ST_SEND);
  assign sd_read   = (state == ST_READ);
  assign sd_cmd    = sd_start ? cmd_frame(step, addr_q) : 48'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      step       <= STEP_CMD0;
      cnt        <= '0;
      retry      <= '0;
      addr_q     <= '0;
      err        <= 1'b0;
      err_code   <= '0;
      card_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      cnt   <= cnt_nxt;
      retry <= retry_nxt;
      if (start_acc) begin
        addr_q   <= block_addr;
        err      <= 1'b0;
        err_code <= '0;
      end
      if (fail) begin
        err      <= 1'b1;
        err_code <= fail_code;
        if (is_init_step(step)) card_ready <= 1'b0;
      end
      if (ready_set) card_ready <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    fail      = 1'b0;
    fail_code = 3'd0;
    ready_set = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_nxt = ST_SEND;
        step_nxt  = card_ready ? STEP_CMD17 : STEP_CMD0;
        cnt_nxt   = '0;
        retry_nxt = '0;
      end
      ST_SEND: state_nxt = ST_SEND_WAIT;
      ST_SEND_WAIT: if (sd_resp_valid) begin
        state_nxt = ST_READ;
        cnt_nxt   = '0;
      end
      ST_READ: state_nxt = ST_READ_WAIT;
      ST_READ_WAIT: if (sd_resp_valid) begin
        state_nxt = ST_READ;
        cnt_nxt   = cnt + 1'b1;
        if (is_r1_step(step) && sd_resp == 8'hFF) begin
          if (cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
            fail = 1'b1; fail_code = ERR_R1_TIMEOUT;
          end
        end else begin
          case (step)
            STEP_CMD0:
              if (sd_resp == 8'h01) begin step_nxt = STEP_CMD8; state_nxt = ST_SEND; end
              else begin fail = 1'b1; fail_code = ERR_CMD0; end
            STEP_CMD8: begin step_nxt = STEP_ECHO; cnt_nxt = '0; end
            STEP_ECHO: if (cnt == 13'd3) begin
              if (sd_resp == 8'hAA) begin step_nxt = STEP_CMD55; state_nxt = ST_SEND; end
              else begin fail = 1'b1; fail_code = ERR_CMD8; end
            end
            STEP_CMD55: begin step_nxt = STEP_ACMD41; state_nxt = ST_SEND; end
            STEP_ACMD41:
              if (sd_resp == 8'h00) begin
                ready_set = 1'b1; step_nxt = STEP_CMD17; state_nxt = ST_SEND;
              end else if (retry == RETRY_W'(INIT_RETRIES - 1)) begin
                fail = 1'b1; fail_code = ERR_RETRY;
              end else begin
                retry_nxt = retry + 1'b1; step_nxt = STEP_CMD55; state_nxt = ST_SEND;
              end
            STEP_CMD17:
              if (sd_resp == 8'h00) begin step_nxt = STEP_TOKEN; cnt_nxt = '0; end
              else begin fail = 1'b1; fail_code = ERR_CMD17; end
            // idle FF polling is bounded; any byte other than FF/FE is a bad token
            STEP_TOKEN:
              if (sd_resp == 8'hFE) begin step_nxt = STEP_DATA; cnt_nxt = '0; end
              else if (sd_resp != 8'hFF || cnt == CNT_W'(TOKEN_TIMEOUT - 1)) begin
                fail = 1'b1; fail_code = ERR_TOKEN;
              end
            STEP_DATA: if (cnt == 13'd511) begin step_nxt = STEP_CRC; cnt_nxt = '0; end
            STEP_CRC:  if (cnt == 13'd1) state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
          endcase
        end
        if (fail) state_nxt = ST_IDLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  sd_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .load     (start_acc),
    .base     (ram_base),
    .byte_vld (byte_vld),
    .byte_dat (sd_resp),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

endmodule
